// File: rtl/dfdd_frame_sequencer_pkg.sv
// Shared types for the DFDD frame sequencer front end.
// FP16 pixel type, FSM states and per-pixel frame markers.
package dfdd_frame_sequencer_pkg;

  localparam int EXP_W  = 5;
  localparam int FRAC_W = 10;

  function automatic int fp_width(input int e, input int f);
    return 1 + e + f;
  endfunction

  localparam int FP16_W = 1 + EXP_W + FRAC_W;

  typedef logic [FP16_W-1:0] fp16_t;

  typedef enum logic [1:0] {
    IDLE,
    STREAM,
    FLUSH
  } state_e;

  typedef struct packed {
    logic sof;
    logic eol;
    logic eof;
  } marker_t;

endpackage

// File: rtl/dfdd_frame_sequencer_if.sv
// Pixel-stream bundle: two valid/ready inputs and the paired,
// valid-only output with raster coordinates and frame markers.
interface dfdd_frame_sequencer_if #(
  parameter int FP_W = 16,
  parameter int CW   = 9,
  parameter int RW   = 9
);
  logic [FP_W-1:0] data_0_i;
  logic            valid_0_i;
  logic            ready_0_o;
  logic [FP_W-1:0] data_1_i;
  logic            valid_1_i;
  logic            ready_1_o;
  logic [FP_W-1:0] data_0_o;
  logic [FP_W-1:0] data_1_o;
  logic            valid_o;
  logic [CW-1:0]   col_o;
  logic [RW-1:0]   row_o;
  logic            sof_o;
  logic            eol_o;
  logic            eof_o;

  modport slave (
    input  data_0_i, valid_0_i,
    input  data_1_i, valid_1_i,
    output ready_0_o, ready_1_o,
    output data_0_o, data_1_o, valid_o,
    output col_o, row_o,
    output sof_o, eol_o, eof_o
  );

  modport master (
    output data_0_i, valid_0_i,
    output data_1_i, valid_1_i,
    input  ready_0_o, ready_1_o,
    input  data_0_o, data_1_o, valid_o,
    input  col_o, row_o,
    input  sof_o, eol_o, eof_o
  );

endinterface

// File: rtl/dfdd_pixel_fifo.sv
// Synchronous pixel FIFO; pointers carry one extra wrap bit
// so full and empty are told apart without a counter.
module dfdd_pixel_fifo #(
  parameter int DATA_WIDTH = 16,
  parameter int DEPTH      = 8
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  clr_i,
  input  logic                  push_i,
  input  logic [DATA_WIDTH-1:0] data_i,
  input  logic                  pop_i,
  output logic [DATA_WIDTH-1:0] data_o,
  output logic                  full_o,
  output logic                  empty_o
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]           wr_q;
  logic [AW:0]           rd_q;
  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic                  do_push;
  logic                  do_pop;

  assign full_o  = (wr_q[AW] != rd_q[AW]) &&
                   (wr_q[AW-1:0] == rd_q[AW-1:0]);
  assign empty_o = (wr_q == rd_q);
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;
  assign data_o  = mem_q[rd_q[AW-1:0]];

  always_ff @(posedge clk_i) begin
    if (rst_i || clr_i) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      if (do_push) wr_q <= wr_q + (AW+1)'(1);
      if (do_pop)  rd_q <= rd_q + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_q[AW-1:0]] <= data_i;
  end

endmodule

// File: rtl/dfdd_frame_sequencer.sv
// Pairs two FP16 streams into raster-ordered pixels, then flushes.
// Optional skew watchdog: DFDD_FRAME_SEQUENCER_SKEW_CHECK_EN.
module dfdd_frame_sequencer
  import dfdd_frame_sequencer_pkg::*;
#(
  parameter int EXP_WIDTH    = 5,
  parameter int FRAC_WIDTH   = 10,
  parameter int IMAGE_WIDTH  = 400,
  parameter int IMAGE_HEIGHT = 400,
  parameter int FIFO_DEPTH   = 8,
  parameter int FLUSH_CYCLES = 64,
  parameter int SKEW_LIMIT   = 256
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 enable_i,
  dfdd_frame_sequencer_if.slave bus,
  output logic                 busy_o,
  output logic                 frame_done_o,
  output logic [15:0]          frame_count_o,
  output logic                 error_o
);

  localparam int FP_W = fp_width(EXP_WIDTH, FRAC_WIDTH);
  localparam int CW   = $clog2(IMAGE_WIDTH);
  localparam int RW   = $clog2(IMAGE_HEIGHT);
  localparam int FW   = $clog2(FLUSH_CYCLES + 1);

  localparam logic [CW-1:0] COL_MAX    = CW'(IMAGE_WIDTH - 1);
  localparam logic [RW-1:0] ROW_MAX    = RW'(IMAGE_HEIGHT - 1);
  localparam logic [FW-1:0] FLUSH_LAST = FW'(FLUSH_CYCLES - 1);

  state_e          state_q;
  logic [CW-1:0]   col_q;
  logic [RW-1:0]   row_q;
  logic [CW-1:0]   ocol_q;
  logic [RW-1:0]   orow_q;
  logic [FW-1:0]   flush_q;
  logic            done_q;
  logic [15:0]     fcnt_q;
  logic            vld_q;
  marker_t         mark_q;
  logic [FP_W-1:0] d0_q;
  logic [FP_W-1:0] d1_q;
  logic [FP_W-1:0] f0_data;
  logic [FP_W-1:0] f1_data;
  logic            full0, empty0;
  logic            full1, empty1;
  logic            push0, push1;
  logic            pop;
  logic            abort;
  logic            aborted;
  logic            col_last, row_last;

  assign bus.ready_0_o = (state_q == STREAM) && !full0;
  assign bus.ready_1_o = (state_q == STREAM) && !full1;
  assign push0    = bus.valid_0_i && bus.ready_0_o;
  assign push1    = bus.valid_1_i && bus.ready_1_o;
  assign pop      = (state_q == STREAM) && !empty0 && !empty1;
  assign col_last = (col_q == COL_MAX);
  assign row_last = (row_q == ROW_MAX);

  dfdd_pixel_fifo #(
    .DATA_WIDTH (FP_W),
    .DEPTH      (FIFO_DEPTH)
  ) u_fifo_0 (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .clr_i   (abort),
    .push_i  (push0),
    .data_i  (bus.data_0_i),
    .pop_i   (pop),
    .data_o  (f0_data),
    .full_o  (full0),
    .empty_o (empty0)
  );

  dfdd_pixel_fifo #(
    .DATA_WIDTH (FP_W),
    .DEPTH      (FIFO_DEPTH)
  ) u_fifo_1 (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .clr_i   (abort),
    .push_i  (push1),
    .data_i  (bus.data_1_i),
    .pop_i   (pop),
    .data_o  (f1_data),
    .full_o  (full1),
    .empty_o (empty1)
  );

`ifdef DFDD_FRAME_SEQUENCER_SKEW_CHECK_EN
  localparam int SW = $clog2(SKEW_LIMIT + 1);

  logic [SW-1:0] skew_q;
  logic          error_q;
  logic          aborted_q;
  logic          skewed;

  assign skewed = (full0 && empty1) || (full1 && empty0);
  assign abort  = (state_q == STREAM) && skewed &&
                  (skew_q == SW'(SKEW_LIMIT - 1));

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      skew_q    <= '0;
      error_q   <= 1'b0;
      aborted_q <= 1'b0;
    end else begin
      if ((state_q == STREAM) && skewed && !abort)
        skew_q <= skew_q + SW'(1);
      else
        skew_q <= '0;
      if (abort) begin
        error_q   <= 1'b1;
        aborted_q <= 1'b1;
      end else if (state_q != FLUSH) begin
        aborted_q <= 1'b0;
      end
    end
  end

  assign error_o = error_q;
  assign aborted = aborted_q;
`else
  assign abort   = 1'b0;
  assign aborted = 1'b0;
  assign error_o = 1'b0;
`endif

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      col_q   <= '0;
      row_q   <= '0;
      ocol_q  <= '0;
      orow_q  <= '0;
      flush_q <= '0;
      done_q  <= 1'b0;
      fcnt_q  <= '0;
      vld_q   <= 1'b0;
      mark_q  <= '0;
      d0_q    <= '0;
      d1_q    <= '0;
    end else begin
      done_q <= 1'b0;
      vld_q  <= pop;
      mark_q <= '0;
      if (pop) begin
        d0_q       <= f0_data;
        d1_q       <= f1_data;
        ocol_q     <= col_q;
        orow_q     <= row_q;
        mark_q.sof <= (col_q == '0) && (row_q == '0);
        mark_q.eol <= col_last;
        mark_q.eof <= col_last && row_last;
        col_q      <= col_last ? '0 : col_q + CW'(1);
        if (col_last)
          row_q <= row_last ? '0 : row_q + RW'(1);
      end
      unique case (state_q)
        IDLE: begin
          if (enable_i) state_q <= STREAM;
        end
        STREAM: begin
          if (abort || (pop && col_last && row_last)) begin
            state_q <= FLUSH;
            flush_q <= '0;
            done_q  <= (FLUSH_CYCLES == 1);
          end
          // an aborted frame restarts its raster from the origin
          if (abort) begin
            col_q <= '0;
            row_q <= '0;
          end
        end
        FLUSH: begin
          if (flush_q == FLUSH_LAST) begin
            state_q <= enable_i ? STREAM : IDLE;
            if (!aborted) fcnt_q <= fcnt_q + 16'd1;
          end else begin
            flush_q <= flush_q + FW'(1);
            done_q  <= ((flush_q + FW'(1)) == FLUSH_LAST);
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.data_0_o  = d0_q;
  assign bus.data_1_o  = d1_q;
  assign bus.valid_o   = vld_q;
  assign bus.col_o     = ocol_q;
  assign bus.row_o     = orow_q;
  assign bus.sof_o     = mark_q.sof;
  assign bus.eol_o     = mark_q.eol;
  assign bus.eof_o     = mark_q.eof;
  assign busy_o        = (state_q != IDLE);
  assign frame_done_o  = done_q;
  assign frame_count_o = fcnt_q;

endmodule

// File: tb/tb_dfdd_frame_sequencer.sv
// Directed bench for dfdd_frame_sequencer on a 4x3 frame.
// Skew-abort steps run only with DFDD_FRAME_SEQUENCER_SKEW_CHECK_EN.
module tb_dfdd_frame_sequencer;

  localparam int W   = 4;
  localparam int H   = 3;
  localparam int DEP = 4;
  localparam int FL  = 5;
  localparam int SK  = 8;
  localparam int NPX = W * H;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        en  = 1'b0;
  logic        busy;
  logic        done;
  logic        err;
  logic [15:0] fcnt;
  int          n_chk  = 0;
  int          n_pass = 0;

  dfdd_frame_sequencer_if #(.FP_W(16), .CW(2), .RW(2)) bus ();

  dfdd_frame_sequencer #(
    .EXP_WIDTH    (5),
    .FRAC_WIDTH   (10),
    .IMAGE_WIDTH  (W),
    .IMAGE_HEIGHT (H),
    .FIFO_DEPTH   (DEP),
    .FLUSH_CYCLES (FL),
    .SKEW_LIMIT   (SK)
  ) dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .enable_i      (en),
    .bus           (bus),
    .busy_o        (busy),
    .frame_done_o  (done),
    .frame_count_o (fcnt),
    .error_o       (err)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // stream 1 starts dly cycles after stream 0; stops after nmax outputs
  task automatic run_stream(input int dly, input int nmax);
    int   p0;
    int   p1;
    int   nout;
    int   cyc;
    int   t_hs1;
    logic hs0;
    logic hs1;
    p0 = 0; p1 = 0; nout = 0; cyc = 0; t_hs1 = -1;
    while (nout < nmax && cyc < 100) begin
      bus.valid_0_i = (p0 < NPX);
      bus.data_0_i  = 16'h3C00 + 16'(p0);
      bus.valid_1_i = (cyc >= dly) && (p1 < NPX);
      bus.data_1_i  = 16'h3C00 + 16'(p1);
      if (p0 == DEP - 1 && p1 == 0)
        chk("rdy0_open", bus.ready_0_o, 1);
      if (p0 == DEP && p1 == 0)
        chk("rdy0_full", bus.ready_0_o, 0);
      hs0 = bus.valid_0_i && bus.ready_0_o;
      hs1 = bus.valid_1_i && bus.ready_1_o;
      if (hs1 && t_hs1 < 0) t_hs1 = cyc;
      tick();
      cyc++;
      if (hs0) p0++;
      if (hs1) p1++;
      if (bus.valid_o) begin
        if (nout == 0) chk("latency", cyc, t_hs1 + 2);
        chk("data0", bus.data_0_o, 32'h3C00 + nout);
        chk("data1", bus.data_1_o, 32'h3C00 + nout);
        chk("col", bus.col_o, nout % W);
        chk("row", bus.row_o, nout / W);
        chk("sof", bus.sof_o, nout == 0);
        chk("eol", bus.eol_o, (nout % W) == W - 1);
        chk("eof", bus.eof_o, nout == NPX - 1);
        nout++;
      end
    end
    bus.valid_0_i = 1'b0;
    bus.valid_1_i = 1'b0;
    if (nout < nmax) chk("stream_timeout", nout, nmax);
  endtask

  // entered on the eof cycle, which is the first FLUSH cycle
  task automatic flush_check(input logic nxt_en, input int exp_cnt);
    bus.valid_0_i = 1'b1;
    bus.data_0_i  = 16'hABCD;
    en = nxt_en;
    for (int k = 0; k < FL; k++) begin
      chk("flush_rdy0", bus.ready_0_o, 0);
      chk("flush_rdy1", bus.ready_1_o, 0);
      chk("flush_busy", busy, 1);
      chk("flush_done", done, k == FL - 1);
      if (k == FL - 1) bus.valid_0_i = 1'b0;
      tick();
    end
    chk("frame_count", fcnt, exp_cnt);
    chk("done_clear", done, 0);
    chk("busy_next", busy, nxt_en);
  endtask

  initial begin
    bus.data_0_i  = '0;
    bus.valid_0_i = 1'b0;
    bus.data_1_i  = '0;
    bus.valid_1_i = 1'b0;

    // reset state
    tick();
    tick();
    rst = 1'b0;
    tick();
    chk("rst_valid", bus.valid_o, 0);
    chk("rst_data0", bus.data_0_o, 0);
    chk("rst_data1", bus.data_1_o, 0);
    chk("rst_sof", bus.sof_o, 0);
    chk("rst_eof", bus.eof_o, 0);
    chk("rst_busy", busy, 0);
    chk("rst_rdy0", bus.ready_0_o, 0);
    chk("rst_rdy1", bus.ready_1_o, 0);
    chk("rst_fcnt", fcnt, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);

    // frame 1: lock-step, then back to IDLE
    en = 1'b1;
    tick();
    chk("f1_busy", busy, 1);
    run_stream(0, NPX);
    flush_check(1'b0, 1);

    // frame 2: stream 1 ten cycles late, flush straight into frame 3
    en = 1'b1;
    tick();
    run_stream(10, NPX);
    flush_check(1'b1, 2);

    // frame 3 starts with sof right after FLUSH
    run_stream(0, NPX);
    flush_check(1'b1, 3);

    // frame 4 cut by reset after pixel 6
    run_stream(0, 7);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mrst_valid", bus.valid_o, 0);
    chk("mrst_busy", busy, 0);
    chk("mrst_fcnt", fcnt, 0);
    chk("mrst_rdy0", bus.ready_0_o, 0);
    en = 1'b1;
    tick();
    run_stream(0, NPX);
    flush_check(1'b0, 1);

`ifdef DFDD_FRAME_SEQUENCER_SKEW_CHECK_EN
    begin
      int t;
      en = 1'b1;
      tick();
      bus.valid_0_i = 1'b1;
      bus.data_0_i  = 16'h4000;
      t = 0;
      while (bus.ready_0_o && t < 20) begin
        tick();
        t++;
      end
      chk("sk_full", bus.ready_0_o, 0);
      for (int k = 0; k < SK; k++) begin
        chk("sk_err_low", err, 0);
        tick();
      end
      chk("sk_err_set", err, 1);
      chk("sk_busy", busy, 1);
      chk("sk_rdy0", bus.ready_0_o, 0);
      chk("sk_no_eof", bus.eof_o, 0);
      en = 1'b0;
      bus.valid_0_i = 1'b0;
      repeat (FL) tick();
      chk("sk_fcnt", fcnt, 1);
      chk("sk_err_sticky", err, 1);
      chk("sk_idle", busy, 0);
    end
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/dfdd_frame_sequencer.md
Name: dfdd_frame_sequencer

Overview:
- Front-end controller for the dual-scale DFDD pipeline.
- Accepts two independent FP16 pixel streams, one per focus image, each with a valid/ready handshake, and buffers each stream in a small FIFO.
- Pops both FIFOs in lock-step and presents paired pixels to the valid-only datapath, together with raster coordinates and frame markers.
- After each frame it runs a flush window so the window fetchers and convolutions drain before the next frame is admitted.

Parameters:
- EXP_WIDTH, 5, FP exponent bits
- FRAC_WIDTH, 10, FP fraction bits
- IMAGE_WIDTH, 400, pixels per row
- IMAGE_HEIGHT, 400, rows per frame
- FIFO_DEPTH, 8, per-stream FIFO entries; must be a power of 2 and ≥ 2
- FLUSH_CYCLES, 64, idle cycles after the last pixel of a frame; ≥ 1
- SKEW_LIMIT, 256, cycles allowed with one FIFO full while the other is empty (optional feature only)

Ports:
- clk_i  in  1  clock
- rst_i  in  1  reset; one clock; synchronous, active-high
- enable_i  in  1  arm; sampled in IDLE to start a frame
- data_0_i  in  FP_W  stream 0 pixel, where FP_W = 1+EXP_WIDTH+FRAC_WIDTH
- valid_0_i  in  1  stream 0 valid
- ready_0_o  out  1  stream 0 ready
- data_1_i  in  FP_W  stream 1 pixel
- valid_1_i  in  1  stream 1 valid
- ready_1_o  out  1  stream 1 ready
- data_0_o  out  FP_W  paired pixel, stream 0
- data_1_o  out  FP_W  paired pixel, stream 1
- valid_o  out  1  paired pixel valid
- col_o  out  CW  column, where CW = $clog2(IMAGE_WIDTH)
- row_o  out  RW  row, where RW = $clog2(IMAGE_HEIGHT)
- sof_o  out  1  first pixel of frame, qualified by valid_o
- eol_o  out  1  last pixel of row, qualified by valid_o
- eof_o  out  1  last pixel of frame, qualified by valid_o
- busy_o  out  1  state ≠ IDLE
- frame_done_o  out  1  one-cycle pulse at the end of FLUSH
- frame_count_o  out  16  completed frames; wraps 0xFFFF→0
- error_o  out  1  sticky skew error

Behaviour:
- Reset: every output is 0, state is IDLE, both FIFOs are emptied, and all counters are 0. A reset mid-frame discards all buffered pixels; there is no partial-frame output afterwards.
- State machine: IDLE → STREAM when enable_i=1.
- STREAM → FLUSH in the cycle the pixel with col=W-1 and row=H-1 is popped.
- In FLUSH a counter runs 0..FLUSH_CYCLES-1. In the final cycle frame_done_o=1 and frame_count_o increments.
- From FLUSH the next state is STREAM if enable_i=1, otherwise IDLE.
- Handshake: ready_k_o = (state==STREAM) && !full_k. Ready is registered from FIFO occupancy and does not depend on valid_k_i. A push happens when valid_k_i && ready_k_o.
- A push and a pop in the same cycle are both honoured. A full FIFO still deasserts ready in that cycle; there is no pass-through.
- Pairing: a pop occurs when state==STREAM && !empty_0 && !empty_1. Both FIFOs pop together.
- Output latency: outputs are registered, one cycle after the pop. A pixel pushed into an empty FIFO, with the other stream already waiting, appears on valid_o 2 cycles after its handshake.
- When valid_o=0, data outputs hold their last value and all frame markers are 0.
- Coordinates: col increments per pop and wraps at W-1 to 0, at which point row increments; row wraps at H-1.
- sof_o fires when col=0 && row=0; eol_o when col=W-1; eof_o when both are at maximum.
- Pixels arriving during FLUSH or IDLE are not accepted (ready=0). Inputs hold them.
- FIFO: the pointers are log2(FIFO_DEPTH)+1 bits wide. Full when the MSBs differ and the remaining bits are equal; empty when the pointers are equal.
- error_o affects no other behaviour when the optional feature is compiled out.

Optional Feature:
- Macro DFDD_FRAME_SEQUENCER_SKEW_CHECK_EN.
- When defined: a counter increments each STREAM cycle in which one FIFO is full and the other is empty, and clears otherwise.
- When the counter reaches SKEW_LIMIT, error_o is set (sticky until rst_i) and the state goes to FLUSH immediately, discarding both FIFO contents. frame_count_o does not increment for the aborted frame; eof_o is not emitted.
- When undefined: error_o is tied to 0 and no counter logic is generated.

Decomposition:
- Shared dfdd package:
  - fp16 pixel typedef, with width derived from EXP/FRAC
  - state enum {IDLE, STREAM, FLUSH}
  - frame-marker struct {sof, eol, eof}
- Sub-module dfdd_pixel_fifo: synchronous FIFO with parameters DATA_WIDTH and DEPTH, providing push/pop/full/empty. It is instantiated twice.

Test Plan (bench overrides IMAGE_WIDTH=4, IMAGE_HEIGHT=3, FIFO_DEPTH=4, FLUSH_CYCLES=5):
- Reset: enable_i=0 → all outputs 0, busy_o=0, ready_*=0.
- Lock-step streaming: both streams drive 12 pixels (0x3C00+i) every cycle with enable_i=1.
  - valid_o rises 2 cycles after the first handshake.
  - sof_o on pixel 0; eol_o on pixels 3, 7, 11; eof_o on pixel 11.
  - Then 5 FLUSH cycles, frame_done_o pulses, frame_count_o=1.
- Skew: stream 1 starts 10 cycles late.
  - ready_0_o drops after 4 pushes.
  - No valid_o until stream 1 arrives.
  - Pairing is correct, so data_0_o==data_1_o index.
- FLUSH gating: valid_0_i held high during FLUSH → ready_0_o=0 for all 5 cycles; the next frame starts with sof_o when enable_i=1.
- Mid-frame reset: rst_i asserted after pixel 6 → next frame begins at col=0, row=0 with sof_o; frame_count_o=0.
- Optional feature (macro defined, SKEW_LIMIT=8): stream 1 idle → error_o=1 eight cycles after FIFO 0 fills, state goes to FLUSH, frame_count_o is unchanged.
